// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipelined CPU memory stage.
package cpu_pkg;
  localparam int DATA_W = 16;
  localparam logic [1:0] MM_LOAD = 2'b01;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} mem_state_t;

  typedef struct packed {
    logic       wbs;
    logic       wme;
    logic       ni;
    logic [1:0] mm;
  } ctrl_t;

  function automatic logic is_access(input logic wm, input logic [1:0] mm);
    return wm | (mm == MM_LOAD);
  endfunction
endpackage

// File: rtl/memory_access_stage_if.sv
// Data-memory req/ack port; master side is the MEM stage.
interface memory_access_stage_if #(parameter int DATA_W = cpu_pkg::DATA_W);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/memwb_register.sv
// MEM/WB pipeline register; a bubble loads all zeros.
module memwb_register
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bubble,
  input  ctrl_t             ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rdata,
  output ctrl_t             wb_ctrl,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_rdata
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst || bubble) begin
      wb_ctrl       <= '0;
      wb_alu_result <= '0;
      wb_rdata      <= '0;
    end else begin
      wb_ctrl       <= ctrl;
      wb_alu_result <= alu_result;
      wb_rdata      <= rdata;
    end
  end
endmodule

// File: rtl/memory_access_stage.sv
// MEM stage: variable-latency load/store with timeout, upstream stall and MEM/WB register.
module memory_access_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wbs_i,
  input  logic                  wme_i,
  input  logic [1:0]            mm_i,
  input  logic                  wm_i,
  input  logic                  ni_i,
  input  logic [DATA_W-1:0]     alu_result_i,
  input  logic [DATA_W-1:0]     mem_data_i,
  output logic                  stall_o,
  memory_access_stage_if.master mem,
  output logic                  wbs_o,
  output logic                  wme_o,
  output logic                  ni_o,
  output logic [1:0]            mm_o,
  output logic [DATA_W-1:0]     alu_result_o,
  output logic [DATA_W-1:0]     mem_rdata_o,
  output logic                  err_o
);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic              we_q, ld_q, err_q;
  ctrl_t             ctrl_q;

  logic              access, timeout, done, stall, bubble;
  ctrl_t             nxt_ctrl, wb_ctrl;
  logic [DATA_W-1:0] nxt_alu, nxt_rdata;

  assign access  = is_access(wm_i, mm_i);
  assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign done    = mem.ack | timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    bubble    = 1'b1;
    nxt_ctrl  = '{wbs: wbs_i, wme: wme_i, ni: ni_i, mm: mm_i};
    nxt_alu   = alu_result_i;
    nxt_rdata = '0;
    case (state_q)
      IDLE: begin
        if (access) begin
          stall   = 1'b1;
          state_d = ACCESS;
        end else begin
          bubble  = 1'b0;
        end
      end
      ACCESS: begin
        if (done) begin
          state_d   = IDLE;
          bubble    = 1'b0;
          nxt_ctrl  = ctrl_q;
          nxt_alu   = addr_q;
          nxt_rdata = (ld_q && mem.ack) ? mem.rdata : '0;
        end else begin
          stall     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces the state to IDLE asynchronously, but the IDLE decode of
  // stale upstream inputs would still raise stall, so mask it explicitly.
  assign stall_o   = stall & ~rst;
  assign mem.req   = (state_q == ACCESS);
  assign mem.we    = we_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;
  assign err_o     = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ld_q    <= 1'b0;
      ctrl_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && access) begin
        addr_q  <= alu_result_i;
        wdata_q <= mem_data_i;
        we_q    <= wm_i;
        ld_q    <= (mm_i == MM_LOAD) & ~wm_i;
        ctrl_q  <= nxt_ctrl;
      end
      if (state_q == ACCESS) begin
        cnt_q <= done ? '0 : cnt_q + 1'b1;
        if (timeout && !mem.ack) err_q <= 1'b1;
      end
    end
  end

  memwb_register #(.DATA_W(DATA_W)) u_memwb (
    .clk           (clk),
    .rst           (rst),
    .bubble        (bubble),
    .ctrl          (nxt_ctrl),
    .alu_result    (nxt_alu),
    .rdata         (nxt_rdata),
    .wb_ctrl       (wb_ctrl),
    .wb_alu_result (alu_result_o),
    .wb_rdata      (mem_rdata_o)
  );

  assign wbs_o = wb_ctrl.wbs;
  assign wme_o = wb_ctrl.wme;
  assign ni_o  = wb_ctrl.ni;
  assign mm_o  = wb_ctrl.mm;
endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: vector table, corner sequences, random instructions vs. model.
module tb_memory_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_i, wme_i, wm_i, ni_i;
  logic [1:0]  mm_i;
  logic [15:0] alu_result_i, mem_data_i;
  logic        stall_o, wbs_o, wme_o, ni_o, err_o;
  logic [1:0]  mm_o;
  logic [15:0] alu_result_o, mem_rdata_o;

  memory_access_stage_if #(.DATA_W(16)) mem ();

  memory_access_stage #(.DATA_W(16), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .wbs_i(wbs_i), .wme_i(wme_i), .mm_i(mm_i), .wm_i(wm_i),
    .ni_i(ni_i), .alu_result_i(alu_result_i), .mem_data_i(mem_data_i),
    .stall_o(stall_o), .mem(mem), .wbs_o(wbs_o), .wme_o(wme_o), .ni_o(ni_o),
    .mm_o(mm_o), .alu_result_o(alu_result_o), .mem_rdata_o(mem_rdata_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int   tests = 0, fails = 0;
  int   req_rises = 0, last_stall = 0;
  logic prev_req = 1'b0;
  logic exp_err = 1'b0;

  typedef struct {
    logic        wbs, wme, ni;
    logic [1:0]  mm;
    logic        wm;
    logic [15:0] alu, wd;
    int          ack_after;   // ACCESS cycle carrying the ack; 0 = never ack
    logic [15:0] rd;
    logic [15:0] e_rd;
    int          e_stall;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    end
  endtask

  // Issue one instruction, play the memory side, and check against the
  // transaction-level expectation: one MEM/WB result, a fixed stall count.
  task automatic run_instr(input logic wbs, wme, ni, input logic [1:0] mm, input logic wm,
                           input logic [15:0] alu, wd, input int ack_after,
                           input logic [15:0] rd, input string name);
    logic acc, ld, timed, fin;
    int exp_req, reqc, stc;
    logic [15:0] exp_rd;
    acc     = wm | (mm == 2'b01);
    ld      = (mm == 2'b01) && !wm;
    timed   = acc && (ack_after == 0 || ack_after > 16);
    exp_req = !acc ? 0 : (timed ? 16 : ack_after);
    exp_rd  = (ld && !timed) ? rd : 16'h0;
    exp_err = exp_err | timed;
    wbs_i = wbs; wme_i = wme; ni_i = ni; mm_i = mm; wm_i = wm;
    alu_result_i = alu; mem_data_i = wd;
    reqc = 0; stc = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      if (mem.req) mem.ack = (reqc + 1 == ack_after);
      else         mem.ack = 1'($urandom_range(0, 1));
      mem.rdata = (mem.ack && mem.req) ? rd : 16'($urandom);
      @(negedge clk);
      if (mem.req && !prev_req) req_rises++;
      prev_req = mem.req;
      if (mem.req) begin
        reqc++;
        chk({name, ".we"}, mem.we, wm);
        chk({name, ".addr"}, mem.addr, alu);
        chk({name, ".wdata"}, mem.wdata, wd);
        chk({name, ".bubble"}, {alu_result_o, mem_rdata_o, wme_o, wbs_o}, 0);
      end
      if (stall_o) stc++;
      if (!stall_o) fin = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!fin) chk({name, ".timeout_bound"}, 0, 1);
    @(posedge clk); #1;
    mem.ack = 1'b0;
    last_stall = stc;
    chk({name, ".req_cycles"}, reqc, exp_req);
    chk({name, ".stall_cycles"}, stc, exp_req);
    chk({name, ".ctrl"}, {wbs_o, wme_o, ni_o, mm_o}, {wbs, wme, ni, mm});
    chk({name, ".alu_result"}, alu_result_o, alu);
    chk({name, ".rdata"}, mem_rdata_o, exp_rd);
    chk({name, ".err"}, err_o, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0005, 16'h0, 0, 16'h0, 16'h0, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 16'hA5A5, 16'h1, 0, 16'h0, 16'h0, 0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 16'h7FFF, 16'h2, 0, 16'h0, 16'h0, 0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 16'h0010, 16'h0, 3, 16'hBEEF, 16'hBEEF, 3};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 16'h0020, 16'h1234, 1, 16'hCAFE, 16'h0, 1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 16'h0030, 16'h5555, 2, 16'hDEAD, 16'h0, 2};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 16'h0044, 16'h0, 0, 16'h9999, 16'h0, 16};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 16'h0050, 16'h0, 1, 16'h0F0F, 16'h0F0F, 1};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'hFFFF, 16'h0, 0, 16'h0, 16'h0, 0};

    // Reset state, with an access presented upstream to exercise stall masking
    rst = 1'b1; wbs_i = 1'b1; wme_i = 1'b1; ni_i = 1'b1; mm_i = 2'b01; wm_i = 1'b1;
    alu_result_i = 16'h1111; mem_data_i = 16'h2222; mem.ack = 1'b0; mem.rdata = 16'h0;
    #2;
    chk("reset.stall", stall_o, 0);
    chk("reset.req", mem.req, 0);
    chk("reset.outs", {wbs_o, wme_o, ni_o, mm_o, alu_result_o, mem_rdata_o, err_o}, 0);
    chk("reset.bus", {mem.we, mem.addr, mem.wdata}, 0);
    mm_i = 2'b00; wm_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      run_instr(tbl[i].wbs, tbl[i].wme, tbl[i].ni, tbl[i].mm, tbl[i].wm, tbl[i].alu,
                tbl[i].wd, tbl[i].ack_after, tbl[i].rd, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_rdata", i), mem_rdata_o, tbl[i].e_rd);
      chk($sformatf("vec%0d.tbl_stall", i), last_stall, tbl[i].e_stall);
    end
    chk("err.sticky", err_o, 1);

    // Back-to-back loads with single-cycle ack latency
    begin
      int r0;
      r0 = req_rises;
      run_instr(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 16'h0001, 16'h0, 1, 16'hAAAA, "b2b0");
      run_instr(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 16'h0002, 16'h0, 1, 16'hBBBB, "b2b1");
      chk("b2b.req_rises", req_rises - r0, 2);
    end

    // Reset in the 2nd ACCESS cycle abandons the load and clears err
    wbs_i = 1'b1; wme_i = 1'b1; ni_i = 1'b0; mm_i = 2'b01; wm_i = 1'b0;
    alu_result_i = 16'h0040; mem.ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstmid.req_before", mem.req, 1);
    rst = 1'b1; mm_i = 2'b00;
    #1;
    chk("rstmid.req", mem.req, 0);
    chk("rstmid.stall", stall_o, 0);
    chk("rstmid.outs", {wbs_o, wme_o, ni_o, mm_o, alu_result_o, mem_rdata_o, err_o}, 0);
    exp_err = 1'b0;
    @(negedge clk); rst = 1'b0; prev_req = 1'b0;
    @(posedge clk); #1;
    run_instr(1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 16'h0060, 16'h4321, 2, 16'h0, "post_rst");

    // Random instructions against the transaction model
    for (int n = 0; n < 40; n++) begin
      int r, ack;
      r   = $urandom_range(0, 9);
      ack = (r == 0) ? 0 : (r % 4) + 1;
      run_instr(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                ($urandom_range(0, 3) == 0), 16'($urandom), 16'($urandom), ack,
                16'($urandom), $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
